bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Registered round-robin arbiter that shares the single 32-bit CPU bus between NREQ requesters, e.g. the control unit, the I/O/InPort unit and a debug unit.
- Each requester presents a 5-bit bus-source code. The winner's code drives the 32:1 bus multiplexer select.
- Supports locked multi-cycle ownership with a watchdog limit.
- When no requester is granted, the bus select parks on a safe code, so the mux never reaches its undefined default.

Parameters:
NREQ, 4, number of requesters (2..8)
SEL_W, 5, width of bus-source code
PARK_SEL, 0, bus_select code driven when no requester is granted (R0)
MAX_SEL, 24, highest legal source code (C_sign_extended)
MAX_HOLD, 8, maximum consecutive cycles one locked owner may hold the bus (>=2)

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester bus request, level
lock  in  NREQ  per-requester hold request; meaningful only for the current owner
src_sel  in  NREQ*SEL_W  packed source codes; requester i uses bits [i*SEL_W +: SEL_W]
grant  out  NREQ  one-hot grant, registered
bus_select  out  SEL_W  registered select to the bus mux
bus_valid  out  1  high when grant is non-zero
sel_error  out  1  one-cycle pulse: the owner presented a code greater than MAX_SEL
hold_cnt  out  $clog2(MAX_HOLD+1)  consecutive cycles held by the current owner (debug)

Behaviour:
- One clock. Reset is asynchronous and active-low (clr_n), clocked on clk rising edge.
- Reset values:
  - grant = 0
  - bus_select = PARK_SEL
  - bus_valid = 0
  - sel_error = 0
  - hold_cnt = 0
  - round-robin pointer rr_ptr = 0
  - state = IDLE
- Reset mid-grant drops grant immediately (asynchronously), with no completion.
- States:
  - IDLE: no owner.
  - OWN: one owner, single-cycle or locked.
- Latency: a req sampled high at edge n with the bus free produces grant and bus_select valid after edge n. That is one cycle request-to-grant.
- Each edge, keep-condition: state = OWN, req[owner] = 1, lock[owner] = 1, and hold_cnt < MAX_HOLD.
  - If true: the owner keeps its grant and hold_cnt increments.
  - If false: re-arbitrate. Search req starting at rr_ptr, wrapping modulo NREQ. The first set bit wins.
    - Winner found: grant = onehot(winner), hold_cnt = 1, rr_ptr = winner+1 mod NREQ, state = OWN.
    - No winner: grant = 0, bus_select = PARK_SEL, state = IDLE.
- Back-to-back ownership changes are allowed, with no idle bubble.
- A released owner has the lowest priority next round because the pointer has moved past it.
- Watchdog: when hold_cnt = MAX_HOLD, the owner is forcibly re-arbitrated even if lock is still high.
  - If it is the only requester, it is re-granted and hold_cnt restarts at 1.
- bus_select while owned is registered each edge from the owner's current src_sel. This lets a locked owner step through sources, for example R1 then ZLOW.
- If the sampled code is greater than MAX_SEL: bus_select = PARK_SEL and sel_error = 1 for that cycle. The grant is not revoked.
- lock without req is ignored.
- req dropping during OWN ends ownership at the next edge, regardless of lock.
- hold_cnt saturates at MAX_HOLD and is 0 in IDLE.
- Invariants:
  - grant is always one-hot or zero.
  - bus_valid equals the OR of grant.
  - bus_select is never X.

Decomposition:
- Shared package bus_pkg holds:
  - the bus-source code constants (R0..R15 = 0..15, HI = 16, LO = 17, ZHI = 18, ZLO = 19, PC = 20, MDR = 21, INPORT = 22, CSIGN = 24 per the mux encoding in use)
  - SEL_W
  - MAX_SEL
  - the state enum {IDLE, OWN}
- One natural sub-module, rr_pick: a combinational rotating priority encoder. Inputs are req and rr_ptr; outputs are winner index and found.

Test Plan:
- Reset: hold clr_n = 0 with req = 4'b1111 -> grant = 0, bus_select = 0, bus_valid = 0. Release at edge 0 -> grant = 4'b0001 after edge 1.
- Round-robin: req = 4'b1111, lock = 0, src_sel = {3, 7, 20, 21} for i = 3..0 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with bus_select 21, 20, 7, 3, 21.
- Lock: requester 2 is granted with lock = 1 and src_sel changing 5 -> 19 -> 16 -> grant stays 4'b0100 for 3 cycles, bus_select 5, 19, 16, hold_cnt 1, 2, 3. Drop lock -> next requester in order is granted the next cycle.
- Watchdog: requester 1 holds lock = 1 and req[0] = 1, MAX_HOLD = 8 -> grant[1] for exactly 8 cycles, then grant = 4'b0001 on cycle 9.
- Illegal code: the owner presents src_sel = 30 -> bus_select = 0, sel_error pulses high for one cycle, grant is unchanged.
- Async reset mid-lock: assert clr_n low between edges while grant = 4'b0100 -> grant = 0 and bus_select = 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus arbiter: source-select codes, widths and FSM states.
// The code values follow the 32:1 bus mux encoding.
package bus_pkg;

    localparam int unsigned BUS_SEL_W   = 5;
    localparam int unsigned BUS_MAX_SEL = 24;

    typedef logic [BUS_SEL_W-1:0] bus_sel_t;

    localparam bus_sel_t SEL_R0     = 5'd0;
    localparam bus_sel_t SEL_R1     = 5'd1;
    localparam bus_sel_t SEL_R2     = 5'd2;
    localparam bus_sel_t SEL_R3     = 5'd3;
    localparam bus_sel_t SEL_R4     = 5'd4;
    localparam bus_sel_t SEL_R5     = 5'd5;
    localparam bus_sel_t SEL_R6     = 5'd6;
    localparam bus_sel_t SEL_R7     = 5'd7;
    localparam bus_sel_t SEL_R8     = 5'd8;
    localparam bus_sel_t SEL_R9     = 5'd9;
    localparam bus_sel_t SEL_R10    = 5'd10;
    localparam bus_sel_t SEL_R11    = 5'd11;
    localparam bus_sel_t SEL_R12    = 5'd12;
    localparam bus_sel_t SEL_R13    = 5'd13;
    localparam bus_sel_t SEL_R14    = 5'd14;
    localparam bus_sel_t SEL_R15    = 5'd15;
    localparam bus_sel_t SEL_HI     = 5'd16;
    localparam bus_sel_t SEL_LO     = 5'd17;
    localparam bus_sel_t SEL_ZHI    = 5'd18;
    localparam bus_sel_t SEL_ZLO    = 5'd19;
    localparam bus_sel_t SEL_PC     = 5'd20;
    localparam bus_sel_t SEL_MDR    = 5'd21;
    localparam bus_sel_t SEL_INPORT = 5'd22;
    localparam bus_sel_t SEL_CSIGN  = 5'd24;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter_if #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned MAX_HOLD = 8
);
    localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*SEL_W-1:0] src_sel;
    logic [NREQ-1:0]       grant;
    logic [SEL_W-1:0]      bus_select;
    logic                  bus_valid;
    logic                  sel_error;
    logic [HC_W-1:0]       hold_cnt;

    modport master (
        output req,
        output lock,
        output src_sel,
        input  grant,
        input  bus_select,
        input  bus_valid,
        input  sel_error,
        input  hold_cnt
    );

    modport slave (
        input  req,
        input  lock,
        input  src_sel,
        output grant,
        output bus_select,
        output bus_valid,
        output sel_error,
        output hold_cnt
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set bit of req_i at or after rr_ptr_i,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [PTR_W-1:0] winner_o,
    output logic             found_o
);

    int unsigned      pos;
    logic [PTR_W-1:0] idx;

    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        pos      = 0;
        idx      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = 32'(rr_ptr_i) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            idx = PTR_W'(pos);
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Registered round-robin arbiter for the shared CPU bus, with locked ownership,
// a hold watchdog and a parked select whenever the bus is unowned or the code is illegal.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned SEL_W    = BUS_SEL_W,
    parameter int unsigned PARK_SEL = 32'(SEL_R0),
    parameter int unsigned MAX_SEL  = BUS_MAX_SEL,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    bus_arbiter_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned HC_W  = $clog2(MAX_HOLD + 1);

    state_e           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_err_q, sel_err_d;
    logic [HC_W-1:0]  hold_q, hold_d;

    logic [PTR_W-1:0] winner;
    logic             found;
    logic             keep;
    logic [SEL_W-1:0] code;
    logic [SEL_W-1:0] codes [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_codes
        assign codes[g] = bus.src_sel[g*SEL_W +: SEL_W];
    end

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .found_o  (found)
    );

    // A locked owner keeps the bus until it drops req/lock or the watchdog expires.
    assign keep = (state_q == OWN) && bus.req[owner_q] && bus.lock[owner_q] &&
                  (hold_q < HC_W'(MAX_HOLD));

    always_comb begin
        state_d   = IDLE;
        grant_d   = '0;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = '0;
        sel_d     = SEL_W'(PARK_SEL);
        sel_err_d = 1'b0;
        code      = '0;

        if (keep) begin
            state_d = OWN;
            grant_d = grant_q;
            hold_d  = hold_q + HC_W'(1);
            code    = codes[owner_q];
        end else if (found) begin
            state_d  = OWN;
            grant_d  = NREQ'(1) << winner;
            owner_d  = winner;
            rr_ptr_d = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);
            hold_d   = HC_W'(1);
            code     = codes[winner];
        end

        // Out-of-range codes would hit the mux default; park instead and flag it.
        if (state_d == OWN) begin
            if (code > SEL_W'(MAX_SEL)) begin
                sel_err_d = 1'b1;
            end else begin
                sel_d = code;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            sel_q     <= SEL_W'(PARK_SEL);
            sel_err_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            sel_q     <= sel_d;
            sel_err_q <= sel_err_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.bus_select = sel_q;
    assign bus.bus_valid  = |grant_q;
    assign bus.sel_error  = sel_err_q;
    assign bus.hold_cnt   = hold_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: reset, round-robin, lock, illegal code,
// watchdog and asynchronous reset while owned.
module tb_bus_arbiter;

    logic clk;
    logic clr_n;
    int   checks;
    int   failures;
    logic [4:0] c [4];

    bus_arbiter_if #(.NREQ(4), .SEL_W(5), .MAX_HOLD(8)) bif ();

    bus_arbiter #(
        .NREQ     (4),
        .SEL_W    (5),
        .PARK_SEL (0),
        .MAX_SEL  (24),
        .MAX_HOLD (8)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src();
        bif.src_sel = {c[3], c[2], c[1], c[0]};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_own(input string tag, input logic [3:0] g, input logic [4:0] s,
                           input logic [3:0] h);
        chk({tag, ".grant"}, 32'(bif.grant), 32'(g));
        chk({tag, ".sel"}, 32'(bif.bus_select), 32'(s));
        chk({tag, ".valid"}, 32'(bif.bus_valid), 32'(g != 4'b0));
        chk({tag, ".hold"}, 32'(bif.hold_cnt), 32'(h));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr_n    = 1'b0;
        bif.req  = 4'b1111;
        bif.lock = 4'b0000;
        c[0] = 5'd21; c[1] = 5'd20; c[2] = 5'd7; c[3] = 5'd3;
        set_src();

        // Held in reset with everyone requesting.
        tick();
        tick();
        chk_own("reset", 4'b0000, 5'd0, 4'd0);
        chk("reset.err", 32'(bif.sel_error), 32'd0);

        // Round-robin, no lock.
        #2 clr_n = 1'b1;
        tick(); chk_own("rr0", 4'b0001, 5'd21, 4'd1);
        tick(); chk_own("rr1", 4'b0010, 5'd20, 4'd1);
        tick(); chk_own("rr2", 4'b0100, 5'd7, 4'd1);
        tick(); chk_own("rr3", 4'b1000, 5'd3, 4'd1);
        tick(); chk_own("rr4", 4'b0001, 5'd21, 4'd1);

        // Requester 2 locks and steps through sources; pointer sits at 1.
        bif.req = 4'b0100; bif.lock = 4'b0100; c[2] = 5'd5; set_src();
        tick(); chk_own("lock1", 4'b0100, 5'd5, 4'd1);
        c[2] = 5'd19; set_src();
        tick(); chk_own("lock2", 4'b0100, 5'd19, 4'd2);
        c[2] = 5'd16; set_src();
        tick(); chk_own("lock3", 4'b0100, 5'd16, 4'd3);
        bif.lock = 4'b0000; bif.req = 4'b1111;
        tick(); chk_own("unlock", 4'b1000, 5'd3, 4'd1);

        // Illegal code from a locked owner parks the select but keeps the grant.
        bif.req = 4'b1000; bif.lock = 4'b1000; c[3] = 5'd30; set_src();
        tick(); chk_own("ill", 4'b1000, 5'd0, 4'd2);
        chk("ill.err", 32'(bif.sel_error), 32'd1);
        c[3] = 5'd3; set_src();
        tick(); chk_own("ill_after", 4'b1000, 5'd3, 4'd3);
        chk("ill_after.err", 32'(bif.sel_error), 32'd0);

        // Watchdog: requester 1 locked while requester 0 waits.
        bif.req = 4'b0010; bif.lock = 4'b0010;
        tick(); chk_own("wd1", 4'b0010, 5'd20, 4'd1);
        bif.req = 4'b0011;
        for (int i = 2; i <= 8; i++) begin
            tick(); chk_own("wd_hold", 4'b0010, 5'd20, 4'(i));
        end
        tick(); chk_own("wd_expire", 4'b0001, 5'd21, 4'd1);

        // Watchdog with a sole requester re-grants it and restarts the count.
        bif.req = 4'b0001; bif.lock = 4'b0001;
        for (int i = 2; i <= 8; i++) begin
            tick(); chk_own("solo_hold", 4'b0001, 5'd21, 4'(i));
        end
        tick(); chk_own("solo_regrant", 4'b0001, 5'd21, 4'd1);

        // Lock without req is ignored; bus goes idle and parks.
        bif.req = 4'b0000; bif.lock = 4'b1111;
        tick(); chk_own("idle", 4'b0000, 5'd0, 4'd0);

        // Asynchronous reset while requester 2 owns the bus.
        bif.req = 4'b0100; bif.lock = 4'b0100; c[2] = 5'd5; set_src();
        tick(); chk_own("pre_rst", 4'b0100, 5'd5, 4'd1);
        #2 clr_n = 1'b0;
        #1 chk_own("async_rst", 4'b0000, 5'd0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
